ctrl_pipe_hazard: RTL
=====================

Name: ctrl_pipe_hazard

Overview:
- Consumes the decoded control bundle produced by the single-cycle control decoder in ID.
- Carries that bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles; resolves branch/jump in EX and flushes; generates ALU operand forwarding selects.
- Sits between the decoder/register file and the datapath stage registers of the pipelined CPU.

Parameters:
- CNT_W, 16, width of the saturating stall and flush performance counters.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction; 0 = treat bundle as bubble
- id_ctrl  in  9  {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,zero_extnd} from decoder
- id_aluop  in  2  ALUOp from decoder
- id_rs  in  REG_AW  rs field of ID instruction
- id_rt  in  REG_AW  rt field of ID instruction
- id_rd  in  REG_AW  rd field of ID instruction
- ex_zero  in  1  ALU zero flag of the instruction currently in EX
- pc_write  out  1  0 = hold PC
- ifid_write  out  1  0 = hold IF/ID register
- ifid_flush  out  1  1 = clear IF/ID on next edge
- pc_redirect  out  1  EX branch taken or jump; PC takes branch/jump target
- ex_ctrl  out  9  control bundle in EX
- ex_aluop  out  2  ALUOp in EX
- ex_rs, ex_rt  out  REG_AW each  source register numbers in EX
- ex_wreg  out  REG_AW  destination register in EX
- mem_ctrl  out  9  bundle in MEM; only MemRead, MemWrite, MemtoReg, RegWrite are meaningful
- mem_wreg  out  REG_AW  destination in MEM
- wb_ctrl  out  9  bundle in WB; only MemtoReg, RegWrite are meaningful
- wb_wreg  out  REG_AW  destination in WB
- fwd_a, fwd_b  out  2 each  ALU operand A/B select: 00 register file, 10 MEM result, 01 WB result
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (rst_n low, asynchronous): all stage control bundles, ALUOps, register numbers and both counters = 0.
  - With stages empty: pc_write=1, ifid_write=1, ifid_flush=0, pc_redirect=0, fwd_a=fwd_b=00.
  - Reset asserted mid-operation discards all in-flight instructions at once.
- Sanitising: an ID bundle enters EX as a bubble (all 0) when id_valid=0 or any id_ctrl/id_aluop bit is X/Z. The decoder drives X for unknown opcodes; a bubble must never write a register or memory.
- ex_wreg = RegDst ? id_rd : id_rt, captured at the ID->EX edge.
- Stage advance every rising edge: EX->MEM and MEM->WB copy the bundle and wreg unconditionally. The pipeline never stalls past ID.
- pc_redirect (combinational) = ex_ctrl.Branch & (ex_zero | ex_ctrl.Jump). Jump carries Branch=1, so J is unconditional.
- load_use (combinational) = ex_ctrl.MemRead & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt) & id_valid.
- Priority: redirect over load_use.
  - On redirect: ifid_flush=1, pc_write=1, ifid_write=1; ID->EX loads a bubble. Two wrong-path instructions are squashed: the one in IF and the one in ID.
  - On load_use without redirect: pc_write=0, ifid_write=0, ID->EX loads a bubble. Exactly 1 stall cycle per load-use pair.
  - Neither: pc_write=1, ifid_write=1, ifid_flush=0, ID bundle advances.
- Forwarding for A (B is identical with ex_rt):
  - 10 if mem_ctrl.RegWrite & mem_wreg!=0 & mem_wreg==ex_rs;
  - else 01 if wb_ctrl.RegWrite & wb_wreg!=0 & wb_wreg==ex_rs;
  - else 00.
  - MEM wins when both stages match. Register 0 never forwards.
- Counters:
  - stall_cnt +1 on each edge where load_use & ~redirect.
  - flush_cnt +1 on each edge where redirect.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- Latency: the ID bundle appears on ex_ctrl 1 cycle after capture, mem_ctrl after 2, wb_ctrl after 3.

Test Plan:
- Reset: hold rst_n=0, drive ID with LW bundle (id_ctrl=9'b011110000) -> all stage outputs 0, pc_write=1, counters 0. After release, LW appears on ex_ctrl at the first edge.
- Load-use: LW $8 in EX (MemRead=1, ex_wreg=8), ID add with rs=8 -> pc_write=0, ifid_write=0, next ex_ctrl=0, stall_cnt=1. Following cycle: add enters EX with fwd_a=01.
- Branch taken: BEQ in EX with ex_zero=1 -> pc_redirect=1, ifid_flush=1, next ex_ctrl=0, flush_cnt=1. Repeat with ex_zero=0 -> no redirect, counter unchanged.
- Jump plus load-use in the same cycle: J in EX and load_use condition forced true -> redirect wins; pc_write=1, stall_cnt unchanged, flush_cnt+1.
- Forwarding priority: MEM and WB both write $5, EX rs=rt=5 -> fwd_a=fwd_b=10. Repeat with destination $0 -> 00.
- Illegal opcode: id_ctrl all X, id_valid=1 -> ex_ctrl=0 next cycle, no X reaches mem_ctrl/wb_ctrl. Drive 70000 stall cycles -> stall_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/ctrl_pipe_hazard.sv
// Pipeline control for the 5-stage CPU: carries the decoded control bundle ID->EX->MEM->WB,
// resolves load-use stalls and EX-stage redirects, and produces ALU operand forwarding selects.
module ctrl_pipe_hazard #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [8:0]        id_ctrl,
  input  logic [1:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              pc_redirect,
  output logic [8:0]        ex_ctrl,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wreg,
  output logic [8:0]        mem_ctrl,
  output logic [REG_AW-1:0] mem_wreg,
  output logic [8:0]        wb_ctrl,
  output logic [REG_AW-1:0] wb_wreg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // bundle bit positions: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,zero_extnd}
  localparam int C_REGDST   = 8;
  localparam int C_REGWRITE = 5;
  localparam int C_MEMREAD  = 4;
  localparam int C_BRANCH   = 2;
  localparam int C_JUMP     = 1;

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic              id_bad;
  logic              redirect;
  logic              load_use;
  logic              stall;
  logic              bubble;
  logic [REG_AW-1:0] id_wreg;

  // X/Z from the decoder (unknown opcode) must never reach a write-enable downstream
  assign id_bad  = !id_valid || $isunknown({id_ctrl, id_aluop});
  assign id_wreg = id_ctrl[C_REGDST] ? id_rd : id_rt;

  assign redirect = ex_ctrl[C_BRANCH] && (ex_zero || ex_ctrl[C_JUMP]);

  assign load_use = ex_ctrl[C_MEMREAD]
                 && (ex_wreg != REG_ZERO)
                 && ((ex_wreg == id_rs) || (ex_wreg == id_rt))
                 && id_valid;

  assign stall  = load_use && !redirect;
  assign bubble = id_bad || redirect || load_use;

  assign pc_redirect = redirect;
  assign ifid_flush  = redirect;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl  <= '0;
      ex_aluop <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wreg  <= '0;
    end else if (bubble) begin
      ex_ctrl  <= '0;
      ex_aluop <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wreg  <= '0;
    end else begin
      ex_ctrl  <= id_ctrl;
      ex_aluop <= id_aluop;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_wreg  <= id_wreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl <= '0;
      mem_wreg <= '0;
      wb_ctrl  <= '0;
      wb_wreg  <= '0;
    end else begin
      mem_ctrl <= ex_ctrl;
      mem_wreg <= ex_wreg;
      wb_ctrl  <= mem_ctrl;
      wb_wreg  <= mem_wreg;
    end
  end

  // MEM is the younger producer, so it takes precedence over WB
  function automatic logic [1:0] fwd_sel(
    input logic              mem_rw,
    input logic [REG_AW-1:0] mem_dst,
    input logic              wb_rw,
    input logic [REG_AW-1:0] wb_dst,
    input logic [REG_AW-1:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_rw && (mem_dst != REG_ZERO) && (mem_dst == src))
      sel = FWD_MEM;
    else if (wb_rw && (wb_dst != REG_ZERO) && (wb_dst == src))
      sel = FWD_WB;
    return sel;
  endfunction

  assign fwd_a = fwd_sel(mem_ctrl[C_REGWRITE], mem_wreg, wb_ctrl[C_REGWRITE], wb_wreg, ex_rs);
  assign fwd_b = fwd_sel(mem_ctrl[C_REGWRITE], mem_wreg, wb_ctrl[C_REGWRITE], wb_wreg, ex_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
